uart_tx_fifo_param: RTL and testbench

- Parametrised next-generation UART transmitter.
- Configurable data width, baud divisor, parity mode and stop-bit count, fronted by a small transmit FIFO.
- Upstream logic pushes words through a ready/enable handshake; frames are sent back-to-back without idle gaps.
- Sits between the acoustics data packer and the board serial pin.

---
 rtl/uart_tx_fifo_param_if.sv | 21 ++
 rtl/uart_tx_fifo_param.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo_param.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_param_if.sv
// uart_tx_fifo_param_if: push handshake and serial-side status of the FIFO-fronted UART transmitter
interface uart_tx_fifo_param_if #(
  parameter int WORD_SIZE = 8,
  parameter int FIFO_ADDR_WIDTH = 2
);
  logic [WORD_SIZE-1:0] TX_Data_in;
  logic TX_en;
  logic TX_Data_out;
  logic TX_Ready_To_Send;
  logic TX_Busy;
  logic [FIFO_ADDR_WIDTH:0] TX_Fifo_Count;
  logic TX_Overflow;
  modport master (
    output TX_Data_in, TX_en,
    input TX_Data_out, TX_Ready_To_Send, TX_Busy, TX_Fifo_Count, TX_Overflow
  );
  modport slave (
    input TX_Data_in, TX_en,
    output TX_Data_out, TX_Ready_To_Send, TX_Busy, TX_Fifo_Count, TX_Overflow
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: parametrised UART transmitter fed by a circular FIFO, frames sent back-to-back
module uart_tx_fifo_param #(
  parameter int WORD_SIZE = 8,
  parameter int WORD_SIZE_WIDTH = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input logic clk,
  input logic reset_b,
  uart_tx_fifo_param_if.slave tx
);
  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int CW = FIFO_ADDR_WIDTH + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int SW = WORD_SIZE_WIDTH;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [SW-1:0] bit_q, bit_d;
  logic [WORD_SIZE-1:0] sh_q, sh_d;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic par_q, par_d, line_q, line_d, rdy_q, ovf_q, push, pop, tick;
  assign tick = baud_q == BW'(CLKS_PER_BIT - 1);
  assign push = tx.TX_en & rdy_q;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign tx.TX_Data_out = line_q;
  assign tx.TX_Ready_To_Send = rdy_q;
  assign tx.TX_Busy = state_q != IDLE;
  assign tx.TX_Fifo_Count = cnt_q;
  assign tx.TX_Overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    baud_d = tick ? '0 : baud_q + BW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        pop = cnt_q != '0;
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        if (bit_q == SW'(WORD_SIZE - 1)) state_d = PARITY_MODE != 0 ? PARITY : STOP;
        else bit_d = bit_q + SW'(1);
      end
      PARITY: state_d = tick ? STOP : PARITY;
      STOP: if (tick) begin
        if (bit_q == SW'(STOP_BITS - 1)) begin
          pop = cnt_q != '0;
          state_d = IDLE;
        end else bit_d = bit_q + SW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      sh_d = mem_q[rptr_q];
      par_d = ^mem_q[rptr_q] ^ (PARITY_MODE == 1);
    end
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d = '0;
    end
    // line follows the next state so the pin itself is a flop
    line_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      line_q <= 1'b1;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      line_q <= line_d;
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != CW'(DEPTH);
      ovf_q <= tx.TX_en & ~rdy_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx.TX_Data_in;
  end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: three parity/stop configurations driven in parallel against a frame-level model
module tb_uart_tx_fifo_param;
  logic clk = 1'b0;
  logic rst, en;
  logic [7:0] din;
  int passed = 0;
  int total = 0;
  int left = 0;
  logic [10:0] fr [3];
  logic [7:0] q [$];
  bit ovf_m = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_param_if #(.WORD_SIZE(8), .FIFO_ADDR_WIDTH(2)) if0 ();
  uart_tx_fifo_param_if #(.WORD_SIZE(8), .FIFO_ADDR_WIDTH(2)) if1 ();
  uart_tx_fifo_param_if #(.WORD_SIZE(8), .FIFO_ADDR_WIDTH(2)) if2 ();
  assign if0.TX_en = en;
  assign if1.TX_en = en;
  assign if2.TX_en = en;
  assign if0.TX_Data_in = din;
  assign if1.TX_Data_in = din;
  assign if2.TX_Data_in = din;
  uart_tx_fifo_param #(.WORD_SIZE(8), .WORD_SIZE_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(2),
    .STOP_BITS(1), .FIFO_ADDR_WIDTH(2)) u0 (.clk(clk), .reset_b(rst), .tx(if0.slave));
  uart_tx_fifo_param #(.WORD_SIZE(8), .WORD_SIZE_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(1),
    .STOP_BITS(1), .FIFO_ADDR_WIDTH(2)) u1 (.clk(clk), .reset_b(rst), .tx(if1.slave));
  uart_tx_fifo_param #(.WORD_SIZE(8), .WORD_SIZE_WIDTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(0),
    .STOP_BITS(2), .FIFO_ADDR_WIDTH(2)) u2 (.clk(clk), .reset_b(rst), .tx(if2.slave));
  // frame bits in line order: start, 8 data LSB first, parity-or-stop, stop
  function automatic logic [10:0] frame(int c, logic [7:0] w);
    logic p;
    p = c == 0 ? ^w : c == 1 ? ~^w : 1'b1;
    return {1'b1, p, w, 1'b0};
  endfunction
  function automatic logic exp_line(int c);
    return left == 0 ? 1'b1 : fr[c][(44 - left) / 4];
  endfunction
  task automatic step(bit r, bit e, logic [7:0] d);
    bit pop, acc;
    logic [7:0] w;
    if (r) begin
      q.delete();
      left = 0;
      ovf_m = 1'b0;
      return;
    end
    pop = left <= 1 && q.size() > 0;
    ovf_m = e && q.size() == 4;
    acc = e && q.size() < 4;
    if (left > 0) left--;
    if (pop) begin
      w = q.pop_front();
      for (int c = 0; c < 3; c++) fr[c] = frame(c, w);
      left = 44;
    end
    if (acc) q.push_back(d);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  task automatic check_all();
    chk("line_even", 32'(if0.TX_Data_out), 32'(exp_line(0)));
    chk("line_odd", 32'(if1.TX_Data_out), 32'(exp_line(1)));
    chk("line_none_2stop", 32'(if2.TX_Data_out), 32'(exp_line(2)));
    chk("busy0", 32'(if0.TX_Busy), 32'(left != 0));
    chk("busy2", 32'(if2.TX_Busy), 32'(left != 0));
    chk("count0", 32'(if0.TX_Fifo_Count), q.size());
    chk("count1", 32'(if1.TX_Fifo_Count), q.size());
    chk("count2", 32'(if2.TX_Fifo_Count), q.size());
    chk("ready0", 32'(if0.TX_Ready_To_Send), 32'(q.size() != 4));
    chk("ready2", 32'(if2.TX_Ready_To_Send), 32'(q.size() != 4));
    chk("ovf0", 32'(if0.TX_Overflow), 32'(ovf_m));
    chk("ovf1", 32'(if1.TX_Overflow), 32'(ovf_m));
  endtask
  task automatic cyc(input bit r, input bit e, input logic [7:0] d);
    rst = r;
    en = e;
    din = d;
    @(posedge clk);
    step(r, e, d);
    #1;
    check_all();
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    din = '0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(0, 1, 8'hA5);
    repeat (60) cyc(0, 0, 0);
    cyc(0, 1, 8'h01);
    cyc(0, 1, 8'h02);
    cyc(0, 1, 8'h03);
    repeat (150) cyc(0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h10 + i));
    repeat (240) cyc(0, 0, 0);
    for (int i = 0; i < 800; i++) cyc(0, $urandom_range(0, 15) == 0, 8'($urandom));
    repeat (250) cyc(0, 0, 0);
    cyc(0, 1, 8'h3C);
    cyc(0, 1, 8'hC3);
    cyc(0, 1, 8'h5A);
    repeat (8) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (60) cyc(0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
